mod_m_serial_checker: RTL and testbench



---
 rtl/mod_m_serial_checker.sv | 117 +++++++++++
 tb/tb_mod_m_serial_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_m_serial_checker.sv
// rtl/mod_m_serial_checker.sv - serial N-bit operand mod-M remainder and divisibility checker
// One bit per clock; remainder kept below M with a single conditional subtract per step.
module mod_m_serial_checker #(
  parameter int N = 8,
  parameter int M = 3,
  parameter bit LSB_FIRST = 1'b0,
  localparam int RW = ($clog2(M) < 1) ? 1 : $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  num,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rem,
  output logic          is_div
);

  localparam int CW = $clog2(N + 1);
  localparam logic [RW:0]   MOD  = (RW + 1)'(M);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] pow_q, pow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          is_div_q, is_div_d;

  logic          bit_in;
  logic [RW:0]   t_sum, t_red, p_sum, p_red;
  logic [RW-1:0] acc_nxt;
  logic          unused_red_msb;

  // Datapath: both sums stay below 2M, so one compare-subtract is a full reduction.
  always_comb begin
    bit_in = LSB_FIRST ? sh_q[0] : sh_q[N-1];
    if (LSB_FIRST) begin
      t_sum = {1'b0, acc_q} + (bit_in ? {1'b0, pow_q} : '0);
    end else begin
      t_sum = {acc_q, bit_in};
    end
    t_red   = (t_sum >= MOD) ? t_sum - MOD : t_sum;
    p_sum   = {pow_q, 1'b0};
    p_red   = (p_sum >= MOD) ? p_sum - MOD : p_sum;
    acc_nxt = t_red[RW-1:0];
  end

  assign unused_red_msb = t_red[RW] ^ p_red[RW];

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    pow_d    = pow_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sh_d    = num;
          acc_d   = '0;
          pow_d   = RW'(1);
          cnt_d   = '0;
        end
      end
      RUN: begin
        sh_d  = LSB_FIRST ? {1'b0, sh_q[N-1:1]} : {sh_q[N-2:0], 1'b0};
        acc_d = acc_nxt;
        pow_d = p_red[RW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          rem_d    = acc_nxt;
          is_div_d = (acc_nxt == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      acc_q    <= '0;
      pow_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      pow_q    <= pow_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign rem    = rem_q;
  assign is_div = is_div_q;

endmodule

// File: tb/tb_mod_m_serial_checker.sv
// tb/tb_mod_m_serial_checker.sv - directed self-checking bench for mod_m_serial_checker
module tb_mod_m_serial_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // A: N=8 M=3 MSB-first
  logic       start_a = 1'b0;
  logic [7:0] num_a = '0;
  logic       busy_a, done_a, is_div_a;
  logic [1:0] rem_a;
  // B: N=8 M=7 LSB-first
  logic       start_b = 1'b0;
  logic [7:0] num_b = '0;
  logic       busy_b, done_b, is_div_b;
  logic [2:0] rem_b;
  // C: N=16 M=10 MSB-first
  logic        start_c = 1'b0;
  logic [15:0] num_c = '0;
  logic        busy_c, done_c, is_div_c;
  logic [3:0]  rem_c;

  mod_m_serial_checker #(.N(8), .M(3), .LSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num(num_a),
    .busy(busy_a), .done(done_a), .rem(rem_a), .is_div(is_div_a));

  mod_m_serial_checker #(.N(8), .M(7), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num(num_b),
    .busy(busy_b), .done(done_b), .rem(rem_b), .is_div(is_div_b));

  mod_m_serial_checker #(.N(16), .M(10), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .num(num_c),
    .busy(busy_c), .done(done_c), .rem(rem_c), .is_div(is_div_c));

  task automatic run_a(input logic [7:0] v, output int lat);
    @(negedge clk);
    start_a = 1'b1;
    num_a   = v;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_b(input logic [7:0] v, output int lat);
    @(negedge clk);
    start_b = 1'b1;
    num_b   = v;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({busy_a, done_a, rem_a, is_div_a} !== 5'b0)
      $display("FAIL reset_a: got %b want 00000", {busy_a, done_a, rem_a, is_div_a});
    else pass_cnt++;
    total_cnt++;
    if ({busy_b, done_b, rem_b, is_div_b} !== 6'b0)
      $display("FAIL reset_b: got %b want 000000", {busy_b, done_b, rem_b, is_div_b});
    else pass_cnt++;
    total_cnt++;
    if ({busy_c, done_c, rem_c, is_div_c} !== 7'b0)
      $display("FAIL reset_c: got %b want 0000000", {busy_c, done_c, rem_c, is_div_c});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    int lat;
    logic [7:0] vals [3] = '{8'd201, 8'd200, 8'd0};
    logic [1:0] rems [3] = '{2'd0, 2'd2, 2'd0};
    logic       divs [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_a(vals[i], lat);
      total_cnt++;
      if (lat !== 8) $display("FAIL msb_latency[%0d]: got %0d want 8", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (rem_a !== rems[i]) $display("FAIL msb_rem[%0d]: got %0d want %0d", i, rem_a, rems[i]);
      else pass_cnt++;
      total_cnt++;
      if (is_div_a !== divs[i]) $display("FAIL msb_is_div[%0d]: got %b want %b", i, is_div_a, divs[i]);
      else pass_cnt++;
      total_cnt++;
      if (busy_a !== 1'b0) $display("FAIL msb_busy_in_done[%0d]: got %b want 0", i, busy_a);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done_a !== 1'b0) $display("FAIL msb_done_width[%0d]: got %b want 0", i, done_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_lsb_first();
    int lat;
    logic [7:0] vals [3] = '{8'hFF, 8'd252, 8'd6};
    logic [2:0] rems [3] = '{3'd3, 3'd0, 3'd6};
    logic       divs [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_b(vals[i], lat);
      total_cnt++;
      if (lat !== 8) $display("FAIL lsb_latency[%0d]: got %0d want 8", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (rem_b !== rems[i]) $display("FAIL lsb_rem[%0d]: got %0d want %0d", i, rem_b, rems[i]);
      else pass_cnt++;
      total_cnt++;
      if (is_div_b !== divs[i]) $display("FAIL lsb_is_div[%0d]: got %b want %b", i, is_div_b, divs[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    @(negedge clk);
    start_c = 1'b1;
    num_c   = 16'hFFFF;
    @(posedge clk); #1;
    num_c = 16'd1234;
    lat1 = 0;
    while (!done_c && lat1 < 40) begin
      @(posedge clk); #1;
      lat1++;
    end
    total_cnt++;
    if (lat1 !== 16) $display("FAIL b2b_latency1: got %0d want 16", lat1);
    else pass_cnt++;
    total_cnt++;
    if (rem_c !== 4'd5) $display("FAIL b2b_rem1: got %0d want 5", rem_c);
    else pass_cnt++;
    total_cnt++;
    if (busy_c !== 1'b0) $display("FAIL b2b_busy_in_done: got %b want 0", busy_c);
    else pass_cnt++;
    // Edge closing the done cycle re-accepts the held start.
    @(posedge clk); #1;
    start_c = 1'b0;
    total_cnt++;
    if (busy_c !== 1'b1) $display("FAIL b2b_reaccept: got busy %b want 1", busy_c);
    else pass_cnt++;
    lat2 = 0;
    while (!done_c && lat2 < 40) begin
      total_cnt++;
      if (rem_c !== 4'd5) $display("FAIL b2b_rem_hold: got %0d want 5", rem_c);
      else pass_cnt++;
      @(posedge clk); #1;
      lat2++;
    end
    total_cnt++;
    if (lat2 + 1 !== 17) $display("FAIL b2b_done_gap: got %0d want 17", lat2 + 1);
    else pass_cnt++;
    total_cnt++;
    if (rem_c !== 4'd4 || is_div_c !== 1'b0)
      $display("FAIL b2b_rem2: got rem %0d is_div %b want rem 4 is_div 0", rem_c, is_div_c);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int first = -1;
    @(negedge clk);
    start_a = 1'b1;
    num_a   = 8'd100;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 3) begin
        start_a = 1'b1;
        num_a   = 8'd201;
      end
      if (i == 4) start_a = 1'b0;
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    total_cnt++;
    if (first !== 8) $display("FAIL ignore_latency: got %0d want 8", first);
    else pass_cnt++;
    total_cnt++;
    if (ndone !== 1) $display("FAIL ignore_done_count: got %0d want 1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (rem_a !== 2'd1 || is_div_a !== 1'b0)
      $display("FAIL ignore_result: got rem %0d is_div %b want rem 1 is_div 0", rem_a, is_div_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    int lat;
    @(negedge clk);
    start_a = 1'b1;
    num_a   = 8'd200;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy_a, done_a, rem_a, is_div_a} !== 5'b0)
      $display("FAIL midrun_reset: got %b want 00000", {busy_a, done_a, rem_a, is_div_a});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL midrun_no_done: got %0d want 0", ndone);
    else pass_cnt++;
    run_a(8'd99, lat);
    total_cnt++;
    if (lat !== 8 || rem_a !== 2'd0 || is_div_a !== 1'b1)
      $display("FAIL midrun_recover: got lat %0d rem %0d is_div %b want 8 0 1", lat, rem_a, is_div_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
